proc_io_responder: RTL and testbench
====================================

Name: proc_io_responder

Overview:
- Device-side counterpart of the processor's custom I/O instructions.
- Outbound: captures the processor's one-cycle command strobes (snd, uad, sac, ppu_send) with the 32-bit interface_data word into a small command FIFO, drained by downstream peripherals over valid/ready.
- Inbound: latches key and Ethernet receive events and raises one-cycle interrupt_key / interrupt_eth pulses, holding interrupt_source_data stable until the processor acknowledges (RTI).

Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- ACK_TIMEOUT, 1024, cycles in WAIT_ACK before the interrupt is re-signalled; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- snd  in  1  send strobe from processor
- uad  in  1  accelerator-update strobe
- sac  in  1  set-accelerator strobe
- ppu_send  in  1  PPU send strobe
- interface_data  in  32  data word qualified by any strobe
- cmd_valid  out  1  FIFO head valid
- cmd_ready  in  1  downstream accepts head
- cmd_op  out  2  head opcode
- cmd_data  out  32  head data
- cmd_err  out  1  sticky: overflow or strobe collision
- key_event  in  1  one-cycle key press event
- key_data  in  32  key payload, qualified by key_event
- eth_rx_valid  in  1  Ethernet word valid
- eth_rx_data  in  32  Ethernet word
- eth_rx_ready  out  1  responder can accept an Ethernet word
- int_ack  in  1  processor finished the handler (RTI)
- interrupt_key  out  1  one-cycle key interrupt pulse to processor
- interrupt_eth  out  1  one-cycle Ethernet interrupt pulse to processor
- interrupt_source_data  out  32  payload of the interrupt in service

Behaviour:
- Clocking and reset: single clock domain; reset is asynchronous, active-low.
- Reset values:
  - cmd_valid=0, cmd_err=0, eth_rx_ready=1, interrupt_key=0, interrupt_eth=0.
  - interrupt_source_data=0, cmd_op=0, cmd_data=0.
  - FIFO empty, both pend flags clear, FSM in IDLE.
- Reset mid-operation discards all FIFO entries, pending events and the in-service interrupt.
- Opcode encoding: SND=0, UAD=1, SAC=2, PPU=3.
- Strobe capture:
  - When exactly one strobe is high, push {op, interface_data}.
  - When several are high, push only the highest priority (snd > uad > sac > ppu_send) and set cmd_err.
- FIFO:
  - cmd_valid = !empty; cmd_op/cmd_data show the head, combinationally from storage.
  - Pop on cmd_valid & cmd_ready.
  - Push when full without a same-cycle pop: drop the word and set cmd_err.
  - Push when full with a same-cycle pop: accept.
  - Push and pop on empty: the word appears on the head the next cycle (no fall-through).
  - Pointers are log2(CMD_DEPTH)+1 bits with wrap bit.
- cmd_err clears only on reset.
- Key events:
  - key_event sets key_pend and captures key_data.
  - A new key_event while pending overwrites the payload (latest wins).
- Ethernet events:
  - eth_rx_ready = !eth_pend.
  - eth_rx_valid & eth_rx_ready sets eth_pend and captures eth_rx_data.
- Interrupt FSM states: IDLE, SIGNAL, WAIT_ACK.
- IDLE:
  - If key_pend: load interrupt_source_data from the key payload, clear key_pend, src=KEY, go to SIGNAL.
  - Else if eth_pend: load from the Ethernet word, clear eth_pend, src=ETH, go to SIGNAL.
  - Key has priority.
  - An event arriving in the same cycle it is serviced is latched and serviced next.
- SIGNAL:
  - Lasts one cycle; asserts interrupt_key or interrupt_eth per src. Outputs are decoded from registered state.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - interrupt_source_data is held.
  - int_ack returns the FSM to IDLE.
  - int_ack during SIGNAL is honoured: go directly to IDLE.
  - int_ack in IDLE is ignored.
- Latency:
  - Event to interrupt pulse: 2 cycles when the FSM is idle.
  - Back-to-back interrupts are separated by at least one IDLE cycle.
- interrupt_source_data keeps its value in IDLE until the next load.

Optional Feature:
- Macro: PROC_IO_ACK_TIMEOUT_EN.
- Defined: a counter runs in WAIT_ACK.
  - After ACK_TIMEOUT cycles without int_ack, the FSM re-enters SIGNAL with the same src and payload, re-pulsing the interrupt.
  - The counter clears on every entry to WAIT_ACK.
- Undefined: no counter; WAIT_ACK waits indefinitely.

Decomposition:
- Package proc_io_pkg holds:
  - cmd_op_t enum (SND/UAD/SAC/PPU);
  - int_state_t enum (IDLE/SIGNAL/WAIT_ACK);
  - int_src_t (KEY/ETH).
- Sub-module: proc_io_cmd_fifo, a generic synchronous FIFO parameterised by width (34) and depth, with full/empty outputs.

Test Plan:
1. Strobe capture:
   - Stimulus: snd with 0xDEADBEEF, then uad with 0x12345678, cmd_ready=0.
   - Required: cmd_valid=1, head op=0 data=0xDEADBEEF.
   - Then raise cmd_ready: second word op=1 data=0x12345678, then cmd_valid=0.
2. Overflow and collision:
   - Stimulus: with cmd_ready=0, push 5 sac words 0..4.
   - Required: 4 entries retained (0..3), cmd_err=1.
   - Stimulus: after reset, a cycle with snd=sac=1.
   - Required: one entry op=0, cmd_err=1.
3. Full with simultaneous pop:
   - Stimulus: FIFO full, cmd_ready=1 and ppu_send with 0xA5.
   - Required: entry accepted, cmd_err stays 0.
4. Priority and ordering:
   - Stimulus: key_event (0x41) and eth_rx_valid (0x55AA) in the same cycle.
   - Required: interrupt_key pulse 2 cycles later with source_data=0x41, eth_rx_ready=0.
   - Then int_ack: interrupt_eth pulse with 0x55AA, eth_rx_ready returns to 1.
5. Payload hold and reset:
   - Stimulus: no int_ack for 50 cycles.
   - Required: source_data held, no re-pulse (macro undefined).
   - Stimulus: assert rst_n=0 mid-WAIT_ACK.
   - Required: all outputs return to reset values immediately.
6. Timeout (PROC_IO_ACK_TIMEOUT_EN, ACK_TIMEOUT=8):
   - Stimulus: no int_ack.
   - Required: interrupt_eth re-pulses 8 cycles after entering WAIT_ACK, same payload.

Source files
------------

// File: rtl/proc_io_pkg.sv
// Shared types for the processor I/O responder: command opcodes, interrupt FSM states and sources.
package proc_io_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 2;
   localparam int unsigned CMD_W  = OP_W + DATA_W;

   typedef enum logic [1:0] {
      OP_SND = 2'd0,
      OP_UAD = 2'd1,
      OP_SAC = 2'd2,
      OP_PPU = 2'd3
   } cmd_op_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SIGNAL   = 2'd1,
      ST_WAIT_ACK = 2'd2
   } int_state_t;

   typedef enum logic {
      SRC_KEY = 1'b0,
      SRC_ETH = 1'b1
   } int_src_t;

   typedef struct packed {
      cmd_op_t           op;
      logic [DATA_W-1:0] data;
   } cmd_t;

endpackage

// File: rtl/proc_io_cmd_fifo.sv
// Generic synchronous FIFO; head is read combinationally from storage, no fall-through.
module proc_io_cmd_fifo #(
   parameter int unsigned WIDTH = 34,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic             wr_en;
   logic             rd_en;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_en   = pop && !empty;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign wr_en   = push && (!full || rd_en);
   assign rd_data = mem[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
            wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
         end
         if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

endmodule

// File: rtl/proc_io_responder.sv
// Device-side responder for custom I/O instructions: command FIFO outbound, key/Ethernet interrupts inbound.
// Optional PROC_IO_ACK_TIMEOUT_EN re-signals an unacknowledged interrupt after ACK_TIMEOUT cycles.
module proc_io_responder
   import proc_io_pkg::*;
#(
   parameter int unsigned CMD_DEPTH   = 4,
   parameter int unsigned ACK_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              snd,
   input  logic              uad,
   input  logic              sac,
   input  logic              ppu_send,
   input  logic [DATA_W-1:0] interface_data,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [OP_W-1:0]   cmd_op,
   output logic [DATA_W-1:0] cmd_data,
   output logic              cmd_err,
   input  logic              key_event,
   input  logic [DATA_W-1:0] key_data,
   input  logic              eth_rx_valid,
   input  logic [DATA_W-1:0] eth_rx_data,
   output logic              eth_rx_ready,
   input  logic              int_ack,
   output logic              interrupt_key,
   output logic              interrupt_eth,
   output logic [DATA_W-1:0] interrupt_source_data
);

   // ---------------- outbound command path ----------------
   cmd_t    wr_cmd;
   cmd_t    head;
   logic    push;
   logic    collision;
   logic    fifo_full;
   logic    fifo_empty;
   logic    cmd_err_q;

   assign push      = snd | uad | sac | ppu_send;
   assign collision = (snd & (uad | sac | ppu_send)) | (uad & (sac | ppu_send)) | (sac & ppu_send);

   // Highest-priority strobe wins when several fire together.
   always_comb begin
      wr_cmd.data = interface_data;
      wr_cmd.op   = OP_PPU;
      if (snd)      wr_cmd.op = OP_SND;
      else if (uad) wr_cmd.op = OP_UAD;
      else if (sac) wr_cmd.op = OP_SAC;
   end

   proc_io_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data (wr_cmd),
      .pop     (cmd_ready),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign cmd_valid = !fifo_empty;
   assign cmd_op    = head.op;
   assign cmd_data  = head.data;
   assign cmd_err   = cmd_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cmd_err_q <= 1'b0;
      else if (collision || (push && fifo_full && !cmd_ready)) cmd_err_q <= 1'b1;
   end

   // ---------------- inbound event latches ----------------
   logic              key_pend_q;
   logic [DATA_W-1:0] key_payload_q;
   logic              eth_pend_q;
   logic [DATA_W-1:0] eth_payload_q;
   logic              key_clr;
   logic              eth_clr;

   assign eth_rx_ready = !eth_pend_q;

   // A new event in the cycle its predecessor is serviced stays pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_pend_q    <= 1'b0;
         key_payload_q <= '0;
         eth_pend_q    <= 1'b0;
         eth_payload_q <= '0;
      end else begin
         if (key_event) begin
            key_pend_q    <= 1'b1;
            key_payload_q <= key_data;
         end else if (key_clr) begin
            key_pend_q    <= 1'b0;
         end
         if (eth_rx_valid && !eth_pend_q) begin
            eth_pend_q    <= 1'b1;
            eth_payload_q <= eth_rx_data;
         end else if (eth_clr) begin
            eth_pend_q    <= 1'b0;
         end
      end
   end

   // ---------------- interrupt FSM ----------------
   int_state_t        state_q, state_d;
   int_src_t          src_q, src_d;
   logic [DATA_W-1:0] isd_q, isd_d;
   logic              int_key_q;
   logic              int_eth_q;
   logic              timeout;

`ifdef PROC_IO_ACK_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT) + 1;
   logic [CNT_W-1:0] ack_cnt_q;

   // Restarts from zero on every entry to WAIT_ACK.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      ack_cnt_q <= '0;
      else if (state_q != ST_WAIT_ACK) ack_cnt_q <= '0;
      else                             ack_cnt_q <= ack_cnt_q + CNT_W'(1);
   end

   assign timeout = (ack_cnt_q == CNT_W'(ACK_TIMEOUT - 1));
`else
   logic unused_ack_timeout;
   assign unused_ack_timeout = ^32'(ACK_TIMEOUT);
   assign timeout            = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      isd_d   = isd_q;
      key_clr = 1'b0;
      eth_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (key_pend_q) begin
               isd_d   = key_payload_q;
               src_d   = SRC_KEY;
               key_clr = 1'b1;
               state_d = ST_SIGNAL;
            end else if (eth_pend_q) begin
               isd_d   = eth_payload_q;
               src_d   = SRC_ETH;
               eth_clr = 1'b1;
               state_d = ST_SIGNAL;
            end
         end
         ST_SIGNAL:   state_d = int_ack ? ST_IDLE : ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (int_ack)      state_d = ST_IDLE;
            else if (timeout) state_d = ST_SIGNAL;
         end
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         src_q     <= SRC_KEY;
         isd_q     <= '0;
         int_key_q <= 1'b0;
         int_eth_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         isd_q     <= isd_d;
         int_key_q <= (state_d == ST_SIGNAL) && (src_d == SRC_KEY);
         int_eth_q <= (state_d == ST_SIGNAL) && (src_d == SRC_ETH);
      end
   end

   assign interrupt_key         = int_key_q;
   assign interrupt_eth         = int_eth_q;
   assign interrupt_source_data = isd_q;

endmodule

// File: tb/tb_proc_io_responder.sv
// Directed self-checking bench for proc_io_responder (CMD_DEPTH=4, ACK_TIMEOUT=8).
`timescale 1ns/1ps
module tb_proc_io_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        snd, uad, sac, ppu_send;
   logic [31:0] interface_data;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_data;
   logic        cmd_err;
   logic        key_event;
   logic [31:0] key_data;
   logic        eth_rx_valid;
   logic [31:0] eth_rx_data;
   logic        eth_rx_ready;
   logic        int_ack;
   logic        interrupt_key, interrupt_eth;
   logic [31:0] interrupt_source_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   proc_io_responder #(.CMD_DEPTH(4), .ACK_TIMEOUT(8)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .snd                   (snd),
      .uad                   (uad),
      .sac                   (sac),
      .ppu_send              (ppu_send),
      .interface_data        (interface_data),
      .cmd_valid             (cmd_valid),
      .cmd_ready             (cmd_ready),
      .cmd_op                (cmd_op),
      .cmd_data              (cmd_data),
      .cmd_err               (cmd_err),
      .key_event             (key_event),
      .key_data              (key_data),
      .eth_rx_valid          (eth_rx_valid),
      .eth_rx_data           (eth_rx_data),
      .eth_rx_ready          (eth_rx_ready),
      .int_ack               (int_ack),
      .interrupt_key         (interrupt_key),
      .interrupt_eth         (interrupt_eth),
      .interrupt_source_data (interrupt_source_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
      chk({tag, "_cmd_err"},   32'(cmd_err), 32'd0);
      chk({tag, "_cmd_op"},    32'(cmd_op), 32'd0);
      chk({tag, "_cmd_data"},  cmd_data, 32'd0);
      chk({tag, "_eth_rdy"},   32'(eth_rx_ready), 32'd1);
      chk({tag, "_int_key"},   32'(interrupt_key), 32'd0);
      chk({tag, "_int_eth"},   32'(interrupt_eth), 32'd0);
      chk({tag, "_isd"},       interrupt_source_data, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int first_pulse;
      int pulses;
      rst_n = 1'b0;
      {snd, uad, sac, ppu_send} = 4'b0;
      interface_data = '0;
      cmd_ready = 1'b0;
      key_event = 1'b0; key_data = '0;
      eth_rx_valid = 1'b0; eth_rx_data = '0;
      int_ack = 1'b0;
      @(negedge clk);
      check_reset_vals("por");
      rst_n = 1'b1;
      tick();

      // 1. strobe capture and drain
      snd = 1'b1; interface_data = 32'hDEADBEEF; tick();
      snd = 1'b0; uad = 1'b1; interface_data = 32'h12345678; tick();
      uad = 1'b0;
      chk("t1_valid", 32'(cmd_valid), 32'd1);
      chk("t1_op0", 32'(cmd_op), 32'd0);
      chk("t1_data0", cmd_data, 32'hDEADBEEF);
      cmd_ready = 1'b1; tick();
      chk("t1_op1", 32'(cmd_op), 32'd1);
      chk("t1_data1", cmd_data, 32'h12345678);
      tick();
      chk("t1_empty", 32'(cmd_valid), 32'd0);
      chk("t1_err", 32'(cmd_err), 32'd0);
      cmd_ready = 1'b0;

      // 2. overflow: five pushes into four entries
      for (int i = 0; i < 5; i++) begin
         sac = 1'b1; interface_data = 32'(i); tick();
      end
      sac = 1'b0;
      chk("t2_ovf_err", 32'(cmd_err), 32'd1);
      cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t2_valid", 32'(cmd_valid), 32'd1);
         chk("t2_op", 32'(cmd_op), 32'd2);
         chk("t2_data", cmd_data, 32'(i));
         tick();
      end
      chk("t2_drained", 32'(cmd_valid), 32'd0);
      cmd_ready = 1'b0;

      // 2b. collision
      do_reset();
      chk("t2_rst_err", 32'(cmd_err), 32'd0);
      snd = 1'b1; sac = 1'b1; interface_data = 32'h77; tick();
      snd = 1'b0; sac = 1'b0;
      chk("t2c_valid", 32'(cmd_valid), 32'd1);
      chk("t2c_op", 32'(cmd_op), 32'd0);
      chk("t2c_data", cmd_data, 32'h77);
      chk("t2c_err", 32'(cmd_err), 32'd1);
      cmd_ready = 1'b1; tick();
      chk("t2c_one_entry", 32'(cmd_valid), 32'd0);
      cmd_ready = 1'b0;

      // 3. full with simultaneous pop
      do_reset();
      for (int i = 0; i < 4; i++) begin
         snd = 1'b1; interface_data = 32'h10 + 32'(i); tick();
      end
      snd = 1'b0;
      cmd_ready = 1'b1; ppu_send = 1'b1; interface_data = 32'hA5; tick();
      ppu_send = 1'b0;
      chk("t3_err", 32'(cmd_err), 32'd0);
      for (int i = 1; i < 4; i++) begin
         chk("t3_op", 32'(cmd_op), 32'd0);
         chk("t3_data", cmd_data, 32'h10 + 32'(i));
         tick();
      end
      chk("t3_last_valid", 32'(cmd_valid), 32'd1);
      chk("t3_last_op", 32'(cmd_op), 32'd3);
      chk("t3_last_data", cmd_data, 32'hA5);
      tick();
      chk("t3_empty", 32'(cmd_valid), 32'd0);
      chk("t3_err_end", 32'(cmd_err), 32'd0);
      cmd_ready = 1'b0;

      // 4. key has priority over simultaneous Ethernet event
      key_event = 1'b1; key_data = 32'h41;
      eth_rx_valid = 1'b1; eth_rx_data = 32'h55AA;
      tick();
      key_event = 1'b0; eth_rx_valid = 1'b0;
      chk("t4_no_early_key", 32'(interrupt_key), 32'd0);
      chk("t4_eth_rdy_low", 32'(eth_rx_ready), 32'd0);
      tick();
      chk("t4_key_pulse", 32'(interrupt_key), 32'd1);
      chk("t4_no_eth", 32'(interrupt_eth), 32'd0);
      chk("t4_isd_key", interrupt_source_data, 32'h41);
      chk("t4_eth_rdy_held", 32'(eth_rx_ready), 32'd0);
      tick();
      chk("t4_key_one_cycle", 32'(interrupt_key), 32'd0);
      int_ack = 1'b1; tick();
      int_ack = 1'b0;
      chk("t4_idle_gap", 32'(interrupt_eth), 32'd0);
      tick();
      chk("t4_eth_pulse", 32'(interrupt_eth), 32'd1);
      chk("t4_isd_eth", interrupt_source_data, 32'h55AA);
      chk("t4_eth_rdy_back", 32'(eth_rx_ready), 32'd1);

      // 5/6. no acknowledge: hold, or re-pulse after the timeout
      first_pulse = -1;
      pulses = 0;
      for (int i = 1; i <= 50; i++) begin
         tick();
         if (interrupt_eth) begin
            pulses++;
            if (first_pulse < 0) first_pulse = i;
         end
      end
      chk("t5_isd_held", interrupt_source_data, 32'h55AA);
`ifdef PROC_IO_ACK_TIMEOUT_EN
      chk("t6_repulse_cycle", 32'(first_pulse), 32'd9);
`else
      chk("t5_no_repulse", 32'(pulses), 32'd0);
`endif

      // reset in WAIT_ACK with a command queued
      snd = 1'b1; interface_data = 32'hCAFE; tick();
      snd = 1'b0;
      chk("t5_cmd_queued", 32'(cmd_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_vals("t5_rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("t5_post_rst_key", 32'(interrupt_key), 32'd0);
      chk("t5_post_rst_eth", 32'(interrupt_eth), 32'd0);

      // ack during SIGNAL returns straight to IDLE
      key_event = 1'b1; key_data = 32'h99; tick();
      key_event = 1'b0; tick();
      chk("t5_key99_pulse", 32'(interrupt_key), 32'd1);
      int_ack = 1'b1; tick();
      int_ack = 1'b0;
      chk("t5_ack_sig_key", 32'(interrupt_key), 32'd0);
      chk("t5_ack_sig_isd", interrupt_source_data, 32'h99);
      key_event = 1'b1; key_data = 32'h33; tick();
      key_event = 1'b0; tick();
      chk("t5_key33_pulse", 32'(interrupt_key), 32'd1);
      chk("t5_key33_isd", interrupt_source_data, 32'h33);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
